// File: rtl/rsa_job_dispatcher_if.sv
// Bundle of job-input, result-output and exponentiator-link signals for rsa_job_dispatcher.
// The slave view belongs to the dispatcher; the master view is the surrounding environment.
interface rsa_job_dispatcher_if #(
  parameter int BITS  = 4,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [BITS-1:0]  in_x;
  logic [BITS-1:0]  in_e;
  logic [BITS-1:0]  in_m;
  logic             out_valid;
  logic             out_ready;
  logic [BITS-1:0]  out_z;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_err;
  logic [BITS-1:0]  exp_x;
  logic [BITS-1:0]  exp_e;
  logic [BITS-1:0]  exp_m;
  logic             exp_go;
  logic             exp_done;
  logic [BITS-1:0]  exp_z;
  logic             busy;

  modport slave (
    input  in_valid, in_x, in_e, in_m, out_ready, exp_done, exp_z,
    output in_ready, out_valid, out_z, out_tag, out_err,
           exp_x, exp_e, exp_m, exp_go, busy
  );

  modport master (
    output in_valid, in_x, in_e, in_m, out_ready, exp_done, exp_z,
    input  in_ready, out_valid, out_z, out_tag, out_err,
           exp_x, exp_e, exp_m, exp_go, busy
  );
endinterface

// File: rtl/rsa_job_dispatcher.sv
// Job FIFO, launch/collect FSM and timeout guard in front of a modular exponentiator.
//   state    | meaning
//   S_IDLE   | waiting for a queued job and a satisfied exp_go low gap
//   S_RUN    | exp_go held high, waiting for exp_done or timeout
//   S_RESULT | result presented on out_*, waiting for out_ready
module rsa_job_dispatcher #(
  parameter int BITS           = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_W          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 rst_n,
  rsa_job_dispatcher_if.slave io_disp
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int EW = 3 * BITS + TAG_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESULT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [TAG_W-1:0] r_tag_cnt;
  logic [GW-1:0]    r_gap;
  logic [TW-1:0]    r_to;
  logic             r_exp_go;
  logic [BITS-1:0]  r_exp_x;
  logic [BITS-1:0]  r_exp_e;
  logic [BITS-1:0]  r_exp_m;
  logic [TAG_W-1:0] r_tag;
  logic [BITS-1:0]  r_z;
  logic [1:0]       r_err;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_fin_ok;
  logic             w_fin_tmo;
  logic             w_to_last;
  logic [EW-1:0]    w_head;
  logic [BITS-1:0]  w_head_x;
  logic [BITS-1:0]  w_head_e;
  logic [BITS-1:0]  w_head_m;
  logic [TAG_W-1:0] w_head_tag;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = io_disp.in_valid && !w_full;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_x   = w_head[EW-1 -: BITS];
  assign w_head_e   = w_head[EW-BITS-1 -: BITS];
  assign w_head_m   = w_head[TAG_W +: BITS];
  assign w_head_tag = w_head[TAG_W-1:0];
  assign w_to_last  = (r_to == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_tag_cnt <= r_tag_cnt + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: entries are only read behind the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {io_disp.in_x, io_disp.in_e, io_disp.in_m, r_tag_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fin_ok    = 1'b0;
    w_fin_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && (r_gap >= GW'(GAP_CYCLES))) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_m[0] ? S_RUN : S_RESULT;
        end
      end
      S_RUN: begin
        if (io_disp.exp_done) begin
          w_fin_ok    = 1'b1;
          w_state_nxt = S_RESULT;
        end else if (w_to_last) begin
          w_fin_tmo   = 1'b1;
          w_state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        if (io_disp.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap    <= '0;
      r_to     <= '0;
      r_exp_go <= 1'b0;
      r_exp_x  <= '0;
      r_exp_e  <= '0;
      r_exp_m  <= '0;
      r_tag    <= '0;
      r_z      <= '0;
      r_err    <= 2'b00;
    end else begin
      if (r_exp_go)                         r_gap <= '0;
      else if (r_gap != GW'(GAP_CYCLES))    r_gap <= r_gap + 1'b1;
      if (r_state == S_RUN)                 r_to  <= r_to + 1'b1;

      if (w_pop) begin
        r_exp_x <= w_head_x;
        r_exp_e <= w_head_e;
        r_exp_m <= w_head_m;
        r_tag   <= w_head_tag;
        if (w_head_m[0]) begin
          r_exp_go <= 1'b1;
          r_to     <= '0;
        end else begin
          r_z   <= '0;
          r_err <= 2'b10;
        end
      end

      // Done has priority over a coincident timeout.
      if (w_fin_ok) begin
        r_z      <= io_disp.exp_z;
        r_err    <= 2'b00;
        r_exp_go <= 1'b0;
      end else if (w_fin_tmo) begin
        r_z      <= '0;
        r_err    <= 2'b01;
        r_exp_go <= 1'b0;
      end
    end
  end

  assign io_disp.in_ready  = !w_full;
  assign io_disp.out_valid = (r_state == S_RESULT);
  assign io_disp.out_z     = r_z;
  assign io_disp.out_tag   = r_tag;
  assign io_disp.out_err   = r_err;
  assign io_disp.exp_x     = r_exp_x;
  assign io_disp.exp_e     = r_exp_e;
  assign io_disp.exp_m     = r_exp_m;
  assign io_disp.exp_go    = r_exp_go;
  assign io_disp.busy      = !w_empty || (r_state != S_IDLE);
endmodule

// File: tb/tb_rsa_job_dispatcher.sv
// Scoreboard bench for rsa_job_dispatcher with a fixed-latency exponentiator model.
module tb_rsa_job_dispatcher;
  localparam int BITS  = 4;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int TMO   = 64;
  localparam int LAT   = 20;

  typedef struct packed {
    logic [BITS-1:0]  z;
    logic [TAG_W-1:0] tag;
    logic [1:0]       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsa_job_dispatcher_if #(.BITS(BITS), .TAG_W(TAG_W)) bus ();

  rsa_job_dispatcher #(
    .BITS(BITS), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_disp(bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_results = 0;
  int   exp_tag = 0;
  int   go_rises = 0;
  int   hi_len = 0;
  int   lo_len = 0;
  int   model_cnt = 0;
  bit   hang = 1'b0;
  exp_t sb[$];
  exp_t col_e;
  logic [BITS-1:0]  last_z;
  logic [TAG_W-1:0] last_tag;
  logic [1:0]       last_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [BITS-1:0] modexp(input logic [BITS-1:0] x, input logic [BITS-1:0] e,
                                             input logic [BITS-1:0] m);
    int r;
    int mm;
    mm = int'(m);
    if (mm == 0) return '0;
    r = 1 % mm;
    for (int i = 0; i < int'(e); i++) r = (r * int'(x)) % mm;
    return r[BITS-1:0];
  endfunction

  // Exponentiator model: done is seen on the edge LAT cycles after go rose.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            model_cnt <= 0;
    else if (!bus.exp_go)  model_cnt <= 0;
    else                   model_cnt <= model_cnt + 1;
  end
  assign bus.exp_done = bus.exp_go && !hang && (model_cnt == LAT - 1);
  assign bus.exp_z    = modexp(bus.exp_x, bus.exp_e, bus.exp_m);

  always @(negedge clk) begin
    if (!rst_n) begin
      hi_len = 0;
      lo_len = 0;
    end else if (bus.exp_go) begin
      if (hi_len == 0) begin
        chk("gap_before_go", 32'(lo_len >= GAP), 32'd1);
        go_rises++;
      end
      hi_len++;
      lo_len = 0;
    end else begin
      if (hi_len > 0) chk("go_len", hi_len, hang ? TMO : LAT);
      hi_len = 0;
      lo_len++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("stale_result", 32'(sb.size()), 32'd1);
      end else begin
        col_e = sb.pop_front();
        chk("out_z", 32'(bus.out_z), 32'(col_e.z));
        chk("out_tag", 32'(bus.out_tag), 32'(col_e.tag));
        chk("out_err", 32'(bus.out_err), 32'(col_e.err));
      end
      last_z   = bus.out_z;
      last_tag = bus.out_tag;
      last_err = bus.out_err;
      n_results++;
    end
  end

  // Leaves in_valid high so consecutive calls push on consecutive edges.
  task automatic push_job(input logic [BITS-1:0] x, input logic [BITS-1:0] e, input logic [BITS-1:0] m);
    int   n;
    exp_t t;
    n = 0;
    bus.in_x = x;
    bus.in_e = e;
    bus.in_m = m;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    t.err = !m[0] ? 2'b10 : (hang ? 2'b01 : 2'b00);
    t.z   = (t.err != 2'b00) ? '0 : modexp(x, e, m);
    t.tag = exp_tag[TAG_W-1:0];
    sb.push_back(t);
    exp_tag = (exp_tag + 1) % (1 << TAG_W);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue", 32'(sb.size()), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    exp_tag = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_e      = '0;
    bus.in_m      = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_exp_go", 32'(bus.exp_go), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_outs", 32'({bus.out_z, bus.out_tag, bus.out_err, bus.exp_x, bus.exp_e, bus.exp_m}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic job, then bad modulus, then a normal job
    push_job(4'd7, 4'd3, 4'd13);
    wait_idle(200);
    chk("t1_z", 32'(last_z), 32'd5);
    chk("t1_tag", 32'(last_tag), 32'd0);
    chk("t1_err", 32'(last_err), 32'd0);

    r0 = go_rises;
    push_job(4'd3, 4'd2, 4'd12);
    wait_idle(200);
    chk("t2_no_go", go_rises, r0);
    chk("t2_err", 32'(last_err), 32'd2);
    chk("t2_z", 32'(last_z), 32'd0);
    push_job(4'd2, 4'd3, 4'd5);
    wait_idle(200);
    chk("t2_z2", 32'(last_z), 32'd3);
    chk("t2_tag2", 32'(last_tag), 32'd2);

    // Hung exponentiator
    hang = 1'b1;
    push_job(4'd5, 4'd3, 4'd7);
    wait_idle(300);
    hang = 1'b0;
    chk("t3_err", 32'(last_err), 32'd1);
    chk("t3_z", 32'(last_z), 32'd0);
    push_job(4'd4, 4'd2, 4'd9);
    wait_idle(200);
    chk("t3_next_z", 32'(last_z), 32'd7);

    // Backpressure: four in FIFO plus one in flight
    bus.out_ready = 1'b0;
    n0 = n_results;
    for (int i = 0; i < 5; i++) push_job(4'(i + 1), 4'd2, 4'd11);
    bus.in_x = 4'd9;
    bus.in_m = 4'd11;
    chk("t4_full", 32'(bus.in_ready), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("t4_full_hold", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    chk("t4_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_hold_tag", 32'(bus.out_tag), 32'(sb[0].tag));
    chk("t4_hold_z", 32'(bus.out_z), 32'(sb[0].z));
    repeat (5) @(posedge clk);
    #1;
    chk("t4_hold_tag2", 32'(bus.out_tag), 32'(sb[0].tag));
    chk("t4_hold_z2", 32'(bus.out_z), 32'(sb[0].z));
    bus.out_ready = 1'b1;
    wait_idle(800);
    chk("t4_count", n_results - n0, 5);

    // Tag wrap over 17 jobs from a fresh reset
    do_reset();
    for (int i = 0; i < 17; i++)
      push_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
    wait_idle(2000);
    chk("t5_last_tag", 32'(last_tag), 32'd0);

    // Reset in the middle of a job with three queued
    for (int i = 0; i < 4; i++) push_job(4'(i + 3), 4'd3, 4'd13);
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t6_running", 32'(bus.exp_go), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_go_async", 32'(bus.exp_go), 32'd0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    sb.delete();
    exp_tag = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = n_results;
    push_job(4'd6, 4'd5, 4'd11);
    wait_idle(300);
    chk("t6_tag", 32'(last_tag), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("t6_count", n_results - n0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
